// File: rtl/kgp_fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package kgp_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP_INSTR = {DATA_W{1'b0}};

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  // Bundle a returned instruction word with the PC it was fetched from.
  function automatic fetch_entry_t make_entry(input logic [DATA_W-1:0] instr,
                                              input logic [ADDR_W-1:0] pc);
    fetch_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry FIFO of fetch_entry_t with push/pop/clear.
// DEPTH must be a power of two so the pointers wrap naturally.
// An empty FIFO presents an all-zero head entry.
module fetch_fifo
  import kgp_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  fetch_entry_t               wr_data_i,
  input  logic                       pop_i,
  output fetch_entry_t               rd_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok_s;
  logic               pop_ok_s;
  logic               empty_s;

  // Qualify push/pop against full/empty so the state can never be corrupted.
  always_comb begin
    empty_s   = (count_q == {CNT_W{1'b0}});
    push_ok_s = push_i && (count_q != CNT_W'(DEPTH));
    pop_ok_s  = pop_i && !empty_s;
  end

  // Next pointers and occupancy; clear wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clear_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Head entry, forced to zero when nothing is queued.
  always_comb begin
    if (empty_s) begin
      rd_data_o = make_entry(NOP_INSTR, {ADDR_W{1'b0}});
    end else begin
      rd_data_o = mem_q[rd_ptr_q];
    end
    empty_o = empty_s;
    count_o = count_q;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-side prefetch queue: accepts PC fetch addresses, reads the
// synchronous instruction memory and queues {instr, pc} for decode.
// A flush (taken branch) empties the queue and squashes in-flight reads.
// Optional feature: define IFQ_BYPASS_EN to forward a response straight
// to decode when the queue is empty (latency N+1 instead of N+2).
module instr_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = kgp_fetch_pkg::ADDR_W,
  parameter int DATA_W = kgp_fetch_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  import kgp_fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              acc_s;
  logic              rsp_s;
  logic              byp_s;
  logic              pop_s;
  logic              push_s;
  logic              fifo_pop_s;
  logic [CNT_W:0]    inflight_s;
  logic [CNT_W-1:0]  count_s;
  logic              empty_s;
  fetch_entry_t      head_s;
  fetch_entry_t      wr_entry_s;

  // Credit check: queued plus outstanding reads may never exceed DEPTH,
  // so every returning word is guaranteed a free slot.
  always_comb begin
    inflight_s = {1'b0, count_s} + {{CNT_W{1'b0}}, pend_q};
    req_ready  = !flush && (inflight_s < (CNT_W + 1)'(DEPTH));
    acc_s      = req_valid && req_ready;
    imem_en    = acc_s;
    imem_addr  = req_addr;
  end

  // Track the single outstanding read; a flush cycle never accepts, so the
  // pending flag naturally clears behind it.
  always_comb begin
    pend_d = acc_s;
    if (acc_s) begin
      pend_pc_d = req_addr;
    end else begin
      pend_pc_d = pend_pc_q;
    end
  end

  // Pending-read registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= 1'b0;
      pend_pc_q <= {ADDR_W{1'b0}};
    end else begin
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Response handling, output mux and queue control.
  always_comb begin
    rsp_s      = pend_q && !flush;
    wr_entry_s = make_entry(imem_rdata, pend_pc_q);
`ifdef IFQ_BYPASS_EN
    byp_s      = empty_s && rsp_s;
`else
    byp_s      = 1'b0;
`endif
    if (byp_s) begin
      instr_valid = 1'b1;
      instr       = imem_rdata;
      instr_pc    = pend_pc_q;
    end else begin
      instr_valid = !empty_s;
      instr       = head_s.instr;
      instr_pc    = head_s.pc;
    end
    pop_s      = instr_valid && instr_ready;
    push_s     = rsp_s && !(byp_s && instr_ready);
    fifo_pop_s = pop_s && !byp_s && !flush;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (flush),
    .push_i    (push_s),
    .wr_data_i (wr_entry_s),
    .pop_i     (fifo_pop_s),
    .rd_data_o (head_s),
    .empty_o   (empty_s),
    .count_o   (count_s)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (default build).
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;

  instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .flush       (flush),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory model: word = 0xA0 + addr/4, one cycle later.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'hA0 + (imem_addr >> 2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic v, input logic [31:0] d, input logic [31:0] pc);
    chk({tag, "_valid"}, instr_valid, v);
    chk({tag, "_instr"}, instr, d);
    chk({tag, "_pc"}, instr_pc, pc);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    req_addr = 32'h1234;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_imem_en", imem_en, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'h1234);
    head("rst", 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    // Streaming 0x0..0xC with decode always ready
    tick(); req_valid = 1'b1; req_addr = 32'h0; instr_ready = 1'b1; #1;
    chk("s0_imem_en", imem_en, 1'b1);
    chk("s0_imem_addr", imem_addr, 32'h0);
    chk("s0_req_ready", req_ready, 1'b1);
    chk("s0_valid", instr_valid, 1'b0);
    tick(); req_addr = 32'h4; #1;
    chk("s1_valid", instr_valid, 1'b0);
    chk("s1_imem_addr", imem_addr, 32'h4);
    tick(); req_addr = 32'h8; #1;
    head("s2", 1'b1, 32'hA0, 32'h0);
    chk("s2_req_ready", req_ready, 1'b1);
    tick(); req_addr = 32'hC; #1;
    head("s3", 1'b1, 32'hA1, 32'h4);
    tick(); req_valid = 1'b0; #1;
    head("s4", 1'b1, 32'hA2, 32'h8);
    tick(); #1;
    head("s5", 1'b1, 32'hA3, 32'hC);
    tick(); #1;
    head("s6", 1'b0, 32'h0, 32'h0);

    // Backpressure: decode stalled, requests continuous
    tick(); instr_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h10; n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req_ready) n_acc++;
      tick();
      req_addr = 32'h10 + 32'(n_acc) * 32'd4;
    end
    #1;
    chk("bp_accepts", 64'(n_acc), 64'd4);
    chk("bp_req_ready_full", req_ready, 1'b0);
    head("bp_full", 1'b1, 32'hA4, 32'h10);
    req_valid = 1'b0; instr_ready = 1'b1; #1;
    chk("bp_d0_req_ready", req_ready, 1'b0);
    head("bp_d0", 1'b1, 32'hA4, 32'h10);
    tick(); #1;
    chk("bp_d1_req_ready", req_ready, 1'b1);
    head("bp_d1", 1'b1, 32'hA5, 32'h14);
    tick(); #1; head("bp_d2", 1'b1, 32'hA6, 32'h18);
    tick(); #1; head("bp_d3", 1'b1, 32'hA7, 32'h1C);
    tick(); #1; head("bp_d4", 1'b0, 32'h0, 32'h0);

    // Flush with 3 queued entries and one read in flight
    tick(); instr_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h20;
    tick(); req_addr = 32'h24;
    tick(); req_addr = 32'h28;
    tick(); req_addr = 32'h2C; #1;
    chk("f3_req_ready", req_ready, 1'b1);
    tick(); flush = 1'b1; req_addr = 32'h30; #1;
    chk("f4_req_ready", req_ready, 1'b0);
    chk("f4_imem_en", imem_en, 1'b0);
    head("f4", 1'b1, 32'hA8, 32'h20);
    tick(); flush = 1'b0; req_addr = 32'h40; #1;
    chk("f5_valid", instr_valid, 1'b0);
    chk("f5_req_ready", req_ready, 1'b1);
    chk("f5_imem_en", imem_en, 1'b1);
    tick(); req_valid = 1'b0; #1;
    chk("f6_valid", instr_valid, 1'b0);
    tick(); instr_ready = 1'b1; #1;
    head("f7", 1'b1, 32'hB0, 32'h40);
    tick(); #1;
    head("f8", 1'b0, 32'h0, 32'h0);

    // Simultaneous push and pop at count 2, pointers wrapping
    tick(); instr_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h50;
    tick(); req_addr = 32'h54;
    tick(); req_valid = 1'b0;
    tick(); req_valid = 1'b1; req_addr = 32'h58; #1;
    chk("p3_count", dut.u_fifo.count_q, 3'd2);
    head("p3", 1'b1, 32'hB4, 32'h50);
    tick(); req_addr = 32'h5C; instr_ready = 1'b1; #1;
    chk("p4_count", dut.u_fifo.count_q, 3'd2);
    head("p4", 1'b1, 32'hB4, 32'h50);
    tick(); req_valid = 1'b0; #1;
    chk("p5_count", dut.u_fifo.count_q, 3'd2);
    head("p5", 1'b1, 32'hB5, 32'h54);
    tick(); #1;
    chk("p6_count", dut.u_fifo.count_q, 3'd2);
    chk("p6_wr_ptr", dut.u_fifo.wr_ptr_q, 2'd1);
    head("p6", 1'b1, 32'hB6, 32'h58);
    tick(); #1; head("p7", 1'b1, 32'hB7, 32'h5C);
    tick(); #1;
    head("p8", 1'b0, 32'h0, 32'h0);
    chk("p8_rd_ptr", dut.u_fifo.rd_ptr_q, 2'd1);

    // Reset mid-operation with a full credit window and a response arriving
    tick(); instr_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h60;
    tick(); req_addr = 32'h64;
    tick(); req_addr = 32'h68;
    tick(); req_addr = 32'h6C;
    tick(); #1;
    chk("r4_req_ready", req_ready, 1'b0);
    head("r4", 1'b1, 32'hB8, 32'h60);
    rst = 1'b1; req_valid = 1'b0; #1;
    chk("r4_rst_req_ready", req_ready, 1'b1);
    chk("r4_rst_imem_en", imem_en, 1'b0);
    chk("r4_rst_count", dut.u_fifo.count_q, 3'd0);
    head("r4_rst", 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    tick(); #1; chk("r5_valid", instr_valid, 1'b0);
    tick(); req_valid = 1'b1; req_addr = 32'h70; #1;
    chk("r6_valid", instr_valid, 1'b0);
    chk("r6_imem_en", imem_en, 1'b1);
    tick(); req_valid = 1'b0;
    tick(); #1;
    head("r8", 1'b1, 32'hBC, 32'h70);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Fetch-side responder for the program counter. It accepts fetch addresses from `program_counter`, issues reads to the synchronous instruction memory, and buffers the returned words with their PC tags in a small prefetch queue. Decode drains the queue over a valid/ready handshake. A taken branch flushes the queue so that no stale instruction reaches decode.

## Interface
- `DEPTH`, 4: queue entries, a power of two ≥ 2.
- `ADDR_W`, 32: fetch address width.
- `DATA_W`, 32: instruction width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  PC presents a fetch address.
- `req_addr`  in  ADDR_W  fetch address (`pc`).
- `req_ready`  out  1  request accepted this cycle; low stalls the PC.
- `flush`  in  1  taken branch (`Branch`); discard all queued and in-flight fetches.
- `imem_en`  out  1  instruction-memory read enable.
- `imem_addr`  out  ADDR_W  instruction-memory address.
- `imem_rdata`  in  DATA_W  read data, valid one cycle after `imem_en`.
- `instr_valid`  out  1  queue head is valid.
- `instr`  out  DATA_W  head instruction.
- `instr_pc`  out  ADDR_W  PC of the head instruction.
- `instr_ready`  in  1  decode consumes the head.

## Operation
- **Accept:** `acc = req_valid & req_ready`.
  - `imem_en = acc` and `imem_addr = req_addr`, both combinational.
  - On an accept, set `pend` and latch `pend_pc = req_addr`.
- **Return:** in the cycle after an accept, `pend` is 1 and `imem_rdata` is valid. Push `{imem_rdata, pend_pc}` unless the entry is squashed.
- **Credit:** `req_ready = !flush & (count + pend < DEPTH)`. The queue therefore never overflows, and a push is never refused.
- **Pop:** `pop = instr_valid & instr_ready`.
  - `instr` and `instr_pc` show the head entry.
  - When the queue is empty, both read 0 and `instr_valid` is 0.
- **Flush** (has priority over all other events):
  - `count`, the read pointer and the write pointer go to 0.
  - A response returning in the same cycle is dropped.
  - `req_ready` is 0, so nothing is accepted.
  - A pop in the flush cycle is still counted as consumed by decode, but the queue is emptied regardless.
- **Pointers:** read and write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH.
- **Count:** `count` is `log2(DEPTH)+1` bits.
  - Push and pop in the same cycle leave `count` unchanged.
  - Pop while empty is impossible, because `instr_valid` is 0.
- Addresses are passed through unchanged. The block does no alignment checking and no increment.

## Timing
- **Reset values:** `req_ready` = 1, `imem_en` = 0, `imem_addr` = `req_addr` (combinational), `instr_valid` = 0, `instr` = 0, `instr_pc` = 0.
- **Reset internals:** `count` = 0, `pend` = 0, `pend_pc` = 0, pointers = 0.
- **Reset mid-operation:** reset discards the queue and any pending response at once. A response arriving after reset is ignored because `pend` = 0.
- **Latency:** accept in cycle N, data in cycle N+1, `instr_valid` in cycle N+2. This is the no-bypass case; see Configuration.
- **Throughput:** one instruction per cycle while decode is ready. This needs DEPTH ≥ 2.
- **Stall:** when decode stops, the queue fills. With the queue full, `req_ready` drops in the cycle where `count + pend = DEPTH`.
- **Flush recovery:** flush in cycle F, `req_ready` = 1 again in F+1, first new instruction visible at F+3.

## Configuration
- **`IFQ_BYPASS_EN` defined:** when the queue is empty and a non-squashed response arrives, that response drives `instr`, `instr_valid` and `instr_pc` in the same cycle it arrives. Latency is then N+1.
  - If `instr_ready` is also 1 in that cycle, the entry is not written.
  - Otherwise it is pushed normally.
- **`IFQ_BYPASS_EN` undefined:** every response is registered, and latency is N+2.

## Structure
- **Package `kgp_fetch_pkg`:**
  - `ADDR_W` / `DATA_W` constants.
  - `NOP_INSTR` constant, value 0.
  - `fetch_entry_t` struct holding `{instr, pc}`.
- **Sub-module `fetch_fifo`:** generic DEPTH×`fetch_entry_t` storage with push/pop/clear, `count`, and async reset.
- **Top level `instr_fetch_queue`:** contains only the credit, pending and flush logic, plus the bypass mux.

## Test plan
- **Reset:** after reset, with `req_valid` = 1 and `req_addr` = 0x0 → `imem_en` = 1 and `imem_addr` = 0x0 in the same cycle. `instr_valid` = 0 until the data arrives.
- **Streaming:** addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles, memory returns 0xA0..0xA3, `instr_ready` = 1 → pairs (0xA0,0x0)…(0xA3,0xC) are delivered in order, one per cycle.
- **Backpressure:** `instr_ready` = 0 with requests continuous and DEPTH = 4 → exactly 4 accepts, then `req_ready` = 0. Raising `instr_ready` drains 4 entries in order and `req_ready` returns.
- **Flush:** queue holds 3 entries and one response is in flight; assert `flush` → `instr_valid` = 0 in the next cycle and the in-flight word never appears. The next request, 0x40, is delivered with `instr_pc` = 0x40.
- **Simultaneous push and pop:** at `count` = 2 with both push and pop active → `count` stays 2 and the pointers wrap correctly past DEPTH-1.
- **Reset mid-operation:** assert `rst` with a full queue and a pending response → all outputs return to their reset values immediately, and the response arriving after reset is ignored.
